// File: rtl/cmp_req_if.sv
// Handshake and comparator bus around cmp_req_ctrl. The slave modport is the controller's view.
// The master modport is the view of the surrounding requester and comparator.
interface cmp_req_if #(
    parameter int A_width       = 16,
    parameter int B_width       = 16,
    parameter int CMP_OUT_width = 16
);
    logic                     REQ_VALID;
    logic                     REQ_READY;
    logic [A_width-1:0]       REQ_A;
    logic [B_width-1:0]       REQ_B;
    logic [1:0]               REQ_FUN;

    logic [A_width-1:0]       CMP_A;
    logic [B_width-1:0]       CMP_B;
    logic [1:0]               CMP_FUN;
    logic                     CMP_EN;
    logic [CMP_OUT_width-1:0] CMP_RES;
    logic                     CMP_VLD;

    logic                     RSP_VALID;
    logic                     RSP_READY;
    logic                     RSP_TRUE;
    logic [1:0]               RSP_STATUS;
    logic [1:0]               RSP_FUN;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_FUN, CMP_RES, CMP_VLD, RSP_READY,
        input  REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_EN, RSP_VALID, RSP_TRUE, RSP_STATUS, RSP_FUN
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_FUN, CMP_RES, CMP_VLD, RSP_READY,
        output REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_EN, RSP_VALID, RSP_TRUE, RSP_STATUS, RSP_FUN
    );
endinterface

// File: rtl/cmp_req_ctrl.sv
// Request controller in front of a multi-cycle comparator. It accepts one request, pulses the
// comparator, waits with a timeout for the result, then returns a decoded response.
module cmp_req_ctrl #(
    parameter int A_width       = 16,
    parameter int B_width       = 16,
    parameter int CMP_OUT_width = 16,   // must be at least 2 so results 2 and 3 are representable
    parameter int TIMEOUT       = 8     // 1..255
) (
    input logic      CLK_CMP,
    input logic      RST_CMP,
    cmp_req_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FUN_NOP = 2'b00,
        FUN_EQ  = 2'b01,
        FUN_GT  = 2'b10,
        FUN_LT  = 2'b11
    } fun_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_DEC_ERR = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_t;

    typedef struct packed {
        logic    hit;
        status_t status;
    } outcome_t;

    localparam logic [CMP_OUT_width-1:0] RES_0     = '0;
    localparam logic [CMP_OUT_width-1:0] RES_1     = CMP_OUT_width'(1);
    localparam logic [CMP_OUT_width-1:0] RES_2     = CMP_OUT_width'(2);
    localparam logic [CMP_OUT_width-1:0] RES_3     = CMP_OUT_width'(3);
    localparam logic [7:0]               WAIT_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    logic [A_width-1:0] cmp_a_q;
    logic [B_width-1:0] cmp_b_q;
    fun_t               cmp_fun_q;
    logic               cmp_en_q;
    logic [7:0]         wait_cnt;
    logic               rsp_valid_q;
    logic               rsp_true_q;
    status_t            rsp_status_q;
    fun_t               rsp_fun_q;
    outcome_t           dec;

    // Each function has exactly one "true" code and one "false" code; anything else,
    // including any nonzero upper bits, is a decode error.
    function automatic outcome_t decode(input fun_t fun, input logic [CMP_OUT_width-1:0] res);
        outcome_t o;
        o = '{hit: 1'b0, status: ST_DEC_ERR};
        case (fun)
            FUN_NOP: if (res == RES_0) o.status = ST_OK;
            FUN_EQ: begin
                if (res == RES_1)      o = '{hit: 1'b1, status: ST_OK};
                else if (res == RES_0) o.status = ST_OK;
            end
            FUN_GT: begin
                if (res == RES_2)      o = '{hit: 1'b1, status: ST_OK};
                else if (res == RES_0) o.status = ST_OK;
            end
            FUN_LT: begin
                if (res == RES_2)      o = '{hit: 1'b1, status: ST_OK};
                else if (res == RES_3) o.status = ST_OK;
            end
        endcase
        return o;
    endfunction

    assign dec = decode(cmp_fun_q, bus.CMP_RES);

    // NOTE: sequential state is written only with non-blocking assignments, and every register
    // (including the operand holding registers) is cleared by the asynchronous reset.
    always_ff @(posedge CLK_CMP or negedge RST_CMP) begin
        if (!RST_CMP) begin
            state        <= IDLE;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            cmp_fun_q    <= FUN_NOP;
            cmp_en_q     <= 1'b0;
            wait_cnt     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_true_q   <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_fun_q    <= FUN_NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        cmp_a_q   <= bus.REQ_A;
                        cmp_b_q   <= bus.REQ_B;
                        cmp_fun_q <= fun_t'(bus.REQ_FUN);
                        cmp_en_q  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmp_en_q <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.CMP_VLD) begin
                        rsp_true_q   <= dec.hit;
                        rsp_status_q <= dec.status;
                        rsp_fun_q    <= cmp_fun_q;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This is the TIMEOUT-th cycle without a result.
                        rsp_true_q   <= 1'b0;
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_fun_q    <= cmp_fun_q;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.REQ_READY  = (state == IDLE);
    assign bus.CMP_A      = cmp_a_q;
    assign bus.CMP_B      = cmp_b_q;
    assign bus.CMP_FUN    = cmp_fun_q;
    assign bus.CMP_EN     = cmp_en_q;
    assign bus.RSP_VALID  = rsp_valid_q;
    assign bus.RSP_TRUE   = rsp_true_q;
    assign bus.RSP_STATUS = rsp_status_q;
    assign bus.RSP_FUN    = rsp_fun_q;
endmodule

// File: tb/tb_cmp_req_ctrl.sv
// Self-checking bench for cmp_req_ctrl. The bench plays both requester and comparator.
// Expected outcomes come from a rule table and timing arithmetic.
`timescale 1ns/1ps
module tb_cmp_req_ctrl;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int RW = 16;
    localparam int TO = 8;

    logic CLK_CMP = 1'b0;
    logic RST_CMP = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK_CMP = ~CLK_CMP;
    always @(posedge CLK_CMP) cyc <= cyc + 1;

    cmp_req_if #(.A_width(AW), .B_width(BW), .CMP_OUT_width(RW)) bus ();

    cmp_req_ctrl #(.A_width(AW), .B_width(BW), .CMP_OUT_width(RW), .TIMEOUT(TO)) dut (
        .CLK_CMP(CLK_CMP),
        .RST_CMP(RST_CMP),
        .bus    (bus)
    );

    // Legal (function, result) pairs and the outcome each one means; anything else is an error.
    typedef struct packed {
        logic [1:0]  fun;
        logic [15:0] res;
        logic        hit;
    } rule_t;

    rule_t rules [7] = '{
        '{2'd0, 16'd0, 1'b0},
        '{2'd1, 16'd1, 1'b1}, '{2'd1, 16'd0, 1'b0},
        '{2'd2, 16'd2, 1'b1}, '{2'd2, 16'd0, 1'b0},
        '{2'd3, 16'd2, 1'b1}, '{2'd3, 16'd3, 1'b0}
    };

    typedef struct {
        int         lat;
        logic       hit;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        bit          ready_before;
        int          start_cyc;
        int          lat;
        int          en_cnt;
        logic [15:0] ca;
        logic [15:0] cb;
        logic [1:0]  cf;
        logic        hit;
        logic [1:0]  st;
        logic [1:0]  fn;
        bit          hold_ok;
        logic [15:0] ca_end;
        bit          idle_after;
        bit          kept;
    } obs_t;

    // vld_delay = number of WAIT cycles before the single-cycle CMP_VLD pulse; -1 = never.
    function automatic exp_t model(input logic [1:0] fun, input logic [15:0] res, input int vld_delay);
        exp_t e;
        bit   timed_out;
        timed_out = (vld_delay < 0) || (vld_delay >= TO);
        e.lat = timed_out ? TO + 1 : vld_delay + 2;
        e.hit = 1'b0;
        e.st  = timed_out ? 2'b10 : 2'b01;
        if (!timed_out)
            foreach (rules[i])
                if (rules[i].fun == fun && rules[i].res == res) begin
                    e.hit = rules[i].hit;
                    e.st  = 2'b00;
                end
        return e;
    endfunction

    // Runs one transaction from a falling edge and records what the DUT did; no judging here.
    task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] fun,
                          input logic [15:0] res, input int vld_delay, input int hold,
                          input bit pulse, input bit noise, output obs_t o);
        o.ready_before = (bus.REQ_READY === 1'b1);
        o.start_cyc    = cyc;
        o.en_cnt       = 0;
        o.lat          = 0;
        o.hold_ok      = 1'b1;
        bus.REQ_A      = a;
        bus.REQ_B      = b;
        bus.REQ_FUN    = fun;
        bus.REQ_VALID  = 1'b1;
        @(negedge CLK_CMP);
        bus.REQ_VALID  = 1'b0;
        bus.REQ_A      = 16'($urandom);
        bus.REQ_B      = 16'($urandom);
        bus.REQ_FUN    = 2'($urandom);
        o.ca = bus.CMP_A;
        o.cb = bus.CMP_B;
        o.cf = bus.CMP_FUN;
        for (int k = 0; k < 64 && bus.RSP_VALID !== 1'b1; k++) begin
            if (bus.CMP_EN === 1'b1) o.en_cnt++;
            if (k == 0) begin
                bus.CMP_VLD = noise ? 1'($urandom) : 1'b0;
                bus.CMP_RES = 16'($urandom);
            end else begin
                bus.CMP_VLD = (vld_delay >= 0) && (k - 1 == vld_delay);
                bus.CMP_RES = bus.CMP_VLD ? res : 16'($urandom);
            end
            bus.RSP_READY = noise ? 1'($urandom) : 1'b0;
            @(negedge CLK_CMP);
            o.lat++;
        end
        bus.CMP_VLD   = 1'b0;
        bus.RSP_READY = 1'b0;
        if (bus.CMP_EN === 1'b1) o.en_cnt++;
        o.hit = bus.RSP_TRUE;
        o.st  = bus.RSP_STATUS;
        o.fn  = bus.RSP_FUN;
        for (int i = 0; i < hold; i++) begin
            bus.REQ_VALID = pulse && (i == 1);
            bus.REQ_A     = ~a;
            if (noise) begin
                bus.CMP_VLD = 1'($urandom);
                bus.CMP_RES = 16'($urandom);
            end
            @(negedge CLK_CMP);
            if (bus.CMP_EN === 1'b1) o.en_cnt++;
            if (bus.RSP_VALID !== 1'b1 || bus.REQ_READY !== 1'b0 || bus.RSP_TRUE !== o.hit ||
                bus.RSP_STATUS !== o.st || bus.RSP_FUN !== o.fn)
                o.hold_ok = 1'b0;
        end
        bus.REQ_VALID = 1'b0;
        bus.CMP_VLD   = 1'b0;
        o.ca_end      = bus.CMP_A;
        bus.RSP_READY = 1'b1;
        @(negedge CLK_CMP);
        bus.RSP_READY = 1'b0;
        if (bus.CMP_EN === 1'b1) o.en_cnt++;
        o.idle_after = (bus.RSP_VALID === 1'b0) && (bus.REQ_READY === 1'b1);
        o.kept = (bus.RSP_TRUE === o.hit) && (bus.RSP_STATUS === o.st) && (bus.RSP_FUN === o.fn);
    endtask

    task automatic test_reset();
        bus.REQ_VALID = 1'b1; bus.REQ_A = 16'hBEEF; bus.REQ_B = 16'h1111; bus.REQ_FUN = 2'b01;
        bus.CMP_VLD = 1'b0; bus.CMP_RES = '0; bus.RSP_READY = 1'b0;
        repeat (2) @(negedge CLK_CMP);
        n_tests++;
        if (bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.REQ_READY);
        end
        n_tests++;
        if ({bus.CMP_A, bus.CMP_B, bus.CMP_FUN, bus.CMP_EN, bus.RSP_VALID, bus.RSP_TRUE,
             bus.RSP_STATUS, bus.RSP_FUN} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_zero: got cmp_a=%h cmp_en=%b rsp_valid=%b want all 0",
                               bus.CMP_A, bus.CMP_EN, bus.RSP_VALID);
        end
        bus.REQ_VALID = 1'b0;
        RST_CMP = 1'b1;
        @(negedge CLK_CMP);
        n_tests++;
        if (bus.REQ_READY !== 1'b1 || bus.CMP_EN !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: got ready=%b en=%b want 1/0", bus.REQ_READY, bus.CMP_EN);
        end
    endtask

    task automatic test_equal();
        obs_t o;
        do_txn(16'h1234, 16'h1234, 2'b01, 16'd1, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.lat !== 2) begin n_fail++; $display("FAIL equal_latency: got %0d want 2", o.lat); end
        n_tests++;
        if (o.hit !== 1'b1 || o.st !== 2'b00) begin
            n_fail++; $display("FAIL equal_result: got true=%b status=%b want 1/00", o.hit, o.st);
        end
        n_tests++;
        if (o.ca !== 16'h1234 || o.cb !== 16'h1234 || o.cf !== 2'b01) begin
            n_fail++; $display("FAIL equal_cmp_operands: got %h %h %b want 1234 1234 01", o.ca, o.cb, o.cf);
        end
        n_tests++;
        if (o.en_cnt !== 1) begin n_fail++; $display("FAIL equal_cmp_en_count: got %0d want 1", o.en_cnt); end
        n_tests++;
        if (!o.idle_after || !o.kept || o.fn !== 2'b01) begin
            n_fail++; $display("FAIL equal_after_resp: got idle=%b kept=%b fun=%b want 1/1/01", o.idle_after, o.kept, o.fn);
        end
    endtask

    task automatic test_less_false();
        obs_t o;
        do_txn(16'h0010, 16'h0005, 2'b11, 16'd3, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.hit !== 1'b0 || o.st !== 2'b00 || o.fn !== 2'b11) begin
            n_fail++; $display("FAIL less_false_result: got true=%b status=%b fun=%b want 0/00/11", o.hit, o.st, o.fn);
        end
    endtask

    task automatic test_back_pressure();
        obs_t o;
        do_txn(16'h0A0A, 16'h0505, 2'b10, 16'd2, 0, 5, 1'b1, 1'b0, o);
        n_tests++;
        if (!o.hold_ok) begin n_fail++; $display("FAIL bp_hold_stable: got unstable want stable for 5 cycles"); end
        n_tests++;
        if (o.ca_end !== 16'h0A0A) begin
            n_fail++; $display("FAIL bp_pulse_ignored: got cmp_a=%h want 0a0a", o.ca_end);
        end
        n_tests++;
        if (o.hit !== 1'b1 || o.st !== 2'b00 || !o.idle_after) begin
            n_fail++; $display("FAIL bp_result: got true=%b status=%b idle=%b want 1/00/1", o.hit, o.st, o.idle_after);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(16'h7777, 16'h0001, 2'b01, 16'd1, -1, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.lat !== TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, TO + 1); end
        n_tests++;
        if (o.st !== 2'b10 || o.hit !== 1'b0) begin
            n_fail++; $display("FAIL timeout_status: got true=%b status=%b want 0/10", o.hit, o.st);
        end
        n_tests++;
        if (o.en_cnt !== 1) begin n_fail++; $display("FAIL timeout_cmp_en_count: got %0d want 1", o.en_cnt); end
    endtask

    task automatic test_decode_error();
        obs_t o;
        do_txn(16'h0003, 16'h0002, 2'b10, 16'd1, 1, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.st !== 2'b01 || o.hit !== 1'b0) begin
            n_fail++; $display("FAIL decode_err_gt1: got true=%b status=%b want 0/01", o.hit, o.st);
        end
        do_txn(16'h0003, 16'h0003, 2'b01, 16'h0101, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.st !== 2'b01 || o.hit !== 1'b0) begin
            n_fail++; $display("FAIL decode_err_upper_bits: got true=%b status=%b want 0/01", o.hit, o.st);
        end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        bit   saw_rsp;
        do_txn(16'h5555, 16'h5555, 2'b01, 16'd1, 0, 0, 1'b0, 1'b0, o);   // leaves nonzero RSP fields
        bus.REQ_A = 16'hC0DE; bus.REQ_B = 16'h0042; bus.REQ_FUN = 2'b10; bus.REQ_VALID = 1'b1;
        @(negedge CLK_CMP);
        bus.REQ_VALID = 1'b0;
        @(negedge CLK_CMP);
        RST_CMP = 1'b0;
        #1;
        n_tests++;
        if ({bus.CMP_A, bus.CMP_B, bus.CMP_FUN, bus.CMP_EN, bus.RSP_VALID, bus.RSP_TRUE,
             bus.RSP_STATUS, bus.RSP_FUN} !== '0 || bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_outputs: got cmp_a=%h true=%b ready=%b want 0/0/1",
                               bus.CMP_A, bus.RSP_TRUE, bus.REQ_READY);
        end
        @(negedge CLK_CMP);
        RST_CMP = 1'b1;
        saw_rsp = 1'b0;
        bus.CMP_VLD = 1'b1; bus.CMP_RES = 16'd2; bus.RSP_READY = 1'b1;
        repeat (3) begin
            @(negedge CLK_CMP);
            if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) saw_rsp = 1'b1;
        end
        bus.CMP_VLD = 1'b0; bus.RSP_READY = 1'b0;
        n_tests++;
        if (saw_rsp) begin n_fail++; $display("FAIL rst_wait_no_response: got response/busy want idle"); end
        do_txn(16'h0001, 16'h0009, 2'b11, 16'd2, 0, 0, 1'b0, 1'b0, o);
        n_tests++;
        if (o.lat !== 2 || o.hit !== 1'b1 || o.st !== 2'b00 || !o.ready_before) begin
            n_fail++; $display("FAIL rst_wait_next_txn: got lat=%0d true=%b status=%b want 2/1/00", o.lat, o.hit, o.st);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   prev;
        do_txn(16'h0100, 16'h0200, 2'b11, 16'd2, 0, 0, 1'b0, 1'b0, o);
        prev = o.start_cyc;
        for (int i = 0; i < 3; i++) begin
            do_txn(16'($urandom), 16'($urandom), 2'b00, 16'd0, 0, 0, 1'b0, 1'b0, o);
            n_tests++;
            if (!o.ready_before || o.start_cyc - prev !== 4) begin
                n_fail++; $display("FAIL b2b_spacing_%0d: got ready=%b spacing=%0d want 1/4", i, o.ready_before, o.start_cyc - prev);
            end
            prev = o.start_cyc;
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [15:0] a, b, res;
        logic [1:0]  fun;
        int          d, r, m;
        for (int i = 0; i < 25; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            fun = 2'($urandom);
            m   = $urandom_range(0, 4);
            res = (m < 4) ? 16'(m) : (16'($urandom) | 16'h0100);
            r   = $urandom_range(0, 9);
            d   = (r <= 5) ? r % 4 : (r <= 7) ? TO - 1 : (r == 8) ? TO : -1;
            do_txn(a, b, fun, res, d, $urandom_range(0, 2), 1'b0, 1'b1, o);
            e = model(fun, res, d);
            n_tests++;
            if (o.hit !== e.hit || o.st !== e.st || o.fn !== fun) begin
                n_fail++; $display("FAIL rand_%0d_result: got true=%b status=%b fun=%b want %b/%b/%b (res=%h d=%0d)",
                                   i, o.hit, o.st, o.fn, e.hit, e.st, fun, res, d);
            end
            n_tests++;
            if (o.lat !== e.lat || o.en_cnt !== 1) begin
                n_fail++; $display("FAIL rand_%0d_timing: got lat=%0d en=%0d want %0d/1", i, o.lat, o.en_cnt, e.lat);
            end
            n_tests++;
            if (o.ca !== a || o.cb !== b || o.cf !== fun || !o.idle_after || !o.hold_ok) begin
                n_fail++; $display("FAIL rand_%0d_operands: got %h %h %b idle=%b hold=%b want %h %h %b 1 1",
                                   i, o.ca, o.cb, o.cf, o.idle_after, o.hold_ok, a, b, fun);
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_less_false();
        test_back_pressure();
        test_timeout();
        test_decode_error();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500us");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cmp_req_ctrl.md
CMP_REQ_CTRL -- requirements
Module: cmp_req_ctrl

Interface
REQ-001 Parameter A_width, default 16: width of operand A.
REQ-002 Parameter B_width, default 16: width of operand B.
REQ-003 Parameter CMP_OUT_width, default 16: width of the comparator result bus.
REQ-004 Parameter TIMEOUT, default 8: maximum WAIT cycles before the block aborts (range 1..255).
REQ-005 CLK_CMP  in  1  clock; all state changes on the rising edge.
REQ-006 RST_CMP  in  1  reset, asynchronous, active-low.
REQ-007 REQ_VALID  in  1  upstream request valid.
REQ-008 REQ_READY  out  1  block can accept a request.
REQ-009 REQ_A  in  A_width  operand A.
REQ-010 REQ_B  in  B_width  operand B.
REQ-011 REQ_FUN  in  2  function: 00 NOP, 01 equal, 10 greater, 11 less.
REQ-012 CMP_A / CMP_B  out  A_width / B_width  registered operands to the comparator.
REQ-013 CMP_FUN  out  2  registered function to the comparator.
REQ-014 CMP_EN  out  1  comparator enable.
REQ-015 CMP_RES  in  CMP_OUT_width  comparator result.
REQ-016 CMP_VLD  in  1  comparator result-valid flag.
REQ-017 RSP_VALID  out  1  response valid.
REQ-018 RSP_READY  in  1  downstream accepts the response.
REQ-019 RSP_TRUE  out  1  decoded comparison outcome.
REQ-020 RSP_STATUS  out  2  00 OK, 01 decode error, 10 timeout.
REQ-021 RSP_FUN  out  2  function of the completed request.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT, and RESP, encoded in 2 bits.
REQ-023 REQ_READY SHALL be 1 only in IDLE (combinational from state).
REQ-024 IDLE: on REQ_VALID=1 at an edge, the block SHALL capture REQ_A/REQ_B/REQ_FUN into CMP_A/CMP_B/CMP_FUN and go to ISSUE.
REQ-025 CMP_A/CMP_B/CMP_FUN SHALL remain stable from capture until the next accepted request.
REQ-026 ISSUE: CMP_EN SHALL be 1 for exactly this one cycle, and the next state SHALL be WAIT.
REQ-027 In every state other than ISSUE, CMP_EN SHALL be 0.
REQ-028 WAIT: on CMP_VLD=1, the block SHALL capture CMP_RES, decode it, and go to RESP.
REQ-029 WAIT: the block SHALL count cycles with CMP_VLD=0; when the count reaches TIMEOUT, it SHALL go to RESP with RSP_STATUS=10 and RSP_TRUE=0.
REQ-030 The timeout counter SHALL be 8 bits and SHALL be cleared on entry to WAIT.
REQ-031 Decode rules:
- equal: result 1 gives TRUE=1; 0 gives TRUE=0.
- greater: result 2 gives TRUE=1; 0 gives TRUE=0.
- less: result 2 gives TRUE=1; 3 gives TRUE=0.
- NOP: result 0 gives TRUE=0.
REQ-032 Any other result value for the given function (including any nonzero upper bits) SHALL produce RSP_STATUS=01 and RSP_TRUE=0.
REQ-033 RESP: RSP_VALID=1 SHALL be asserted, and RSP_TRUE, RSP_STATUS, and RSP_FUN SHALL be held stable until RSP_READY=1 at an edge, after which the state SHALL return to IDLE.
REQ-034 Nominal latency: with acceptance at edge N, CMP_EN SHALL be high during cycle N..N+1, and RSP_VALID SHALL rise after edge N+2.
REQ-035 Maximum throughput SHALL be one request per 4 cycles; no request SHALL be accepted in ISSUE, WAIT, or RESP.
REQ-036 CMP_VLD seen outside WAIT SHALL be ignored.
REQ-037 RSP_READY seen outside RESP SHALL be ignored.
REQ-038 RSP_TRUE, RSP_STATUS, and RSP_FUN SHALL keep their last values after leaving RESP.

Reset
REQ-039 While RST_CMP=0, the block SHALL hold: state=IDLE; CMP_A, CMP_B, CMP_FUN, CMP_EN, RSP_VALID, RSP_TRUE, RSP_STATUS, RSP_FUN, and the counter all 0; REQ_READY=1.
REQ-040 Reset asserted mid-transaction (ISSUE, WAIT, or RESP) SHALL abort it with no response issued; after release, the first edge SHALL behave as IDLE.

Verification
REQ-041 The bench SHALL cover these scenarios:
- Equal: A=0x1234, B=0x1234, FUN=01, comparator returns 1 -> RSP_TRUE=1, STATUS=00, RSP_VALID 2 cycles after acceptance.
- Less, false case: A=0x0010, B=0x0005, FUN=11, comparator returns 3 -> RSP_TRUE=0, STATUS=00.
- Back-pressure: RSP_READY held 0 for 5 cycles -> RSP_VALID and data stable for all 5 cycles; REQ_READY=0 throughout; a REQ_VALID pulse in that window is not accepted.
- Timeout: CMP_VLD tied 0, TIMEOUT=8 -> RESP reached after 8 WAIT cycles, STATUS=10, CMP_EN pulsed exactly once.
- Decode error: FUN=10, comparator returns 1 -> STATUS=01, RSP_TRUE=0.
- Reset in WAIT: RST_CMP low for 1 cycle -> all outputs 0, REQ_READY=1, no RSP_VALID; next request completes normally.
